// File: rtl/datapath_mc.sv
// Multicycle datapath: accepts one decoded instruction, runs EXEC/MEM/WB with its own register file.
// ALU ops retire 2 cycles after accept, memory ops 3+N; instr_ready stays low and MEM holds while waitrequest is set.
module datapath_mc #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [AW-1:0]   rs,
  input  logic [AW-1:0]   rt,
  input  logic [AW-1:0]   rd,
  input  logic            RegDst,
  input  logic            RegWrite,
  input  logic            ALUSrc,
  input  logic            ZeroExt,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      alu_ctrl,
  input  logic [15:0]     alu_immediate,
  output logic            done,
  output logic [XLEN-1:0] data_address,
  output logic [XLEN-1:0] data_writedata,
  output logic            data_read,
  output logic            data_write,
  input  logic            data_waitrequest,
  input  logic [XLEN-1:0] data_readdata,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [AW-1:0]   dest_q, dest_d;
  logic            regwrite_q, regwrite_d;
  logic            alusrc_q, alusrc_d;
  logic            memread_q, memread_d;
  logic            memwrite_q, memwrite_d;
  logic [2:0]      alu_ctrl_q, alu_ctrl_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [XLEN-1:0] aluout_q, aluout_d, mdr_q, mdr_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;

  logic [XLEN-1:0] imm_ext, op_b, alu_res;
  logic            is_load;

  assign imm_ext = ZeroExt ? XLEN'(alu_immediate) : XLEN'($signed(alu_immediate));
  assign op_b    = alusrc_q ? imm_q : b_q;
  // A store wins when both memory flags are set.
  assign is_load = memread_q & ~memwrite_q;

  always_comb begin
    alu_res = '0;
    case (alu_ctrl_q)
      3'd0:    alu_res = a_q + op_b;
      3'd1:    alu_res = a_q - op_b;
      3'd2:    alu_res = a_q & op_b;
      3'd3:    alu_res = a_q | op_b;
      3'd4:    alu_res = a_q ^ op_b;
      3'd5:    alu_res = XLEN'($signed(a_q) < $signed(op_b));
      3'd6:    alu_res = XLEN'(a_q < op_b);
      3'd7:    alu_res = ~(a_q | op_b);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    dest_d     = dest_q;
    regwrite_d = regwrite_q;
    alusrc_d   = alusrc_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    alu_ctrl_d = alu_ctrl_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    aluout_d   = aluout_q;
    mdr_d      = mdr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          dest_d     = RegDst ? rt : rd;
          regwrite_d = RegWrite;
          alusrc_d   = ALUSrc;
          memread_d  = MemRead;
          memwrite_d = MemWrite;
          alu_ctrl_d = alu_ctrl;
          a_d        = regs_q[rs];
          b_d        = regs_q[rt];
          imm_d      = imm_ext;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        aluout_d = alu_res;
        if (memread_q || memwrite_q) begin
          // Bus address/data live in their own flops so they hold after MEM.
          addr_d  = alu_res;
          wdata_d = b_q;
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (!data_waitrequest) begin
          if (is_load) mdr_d = data_readdata;
          state_d = WB;
        end
      end
      WB: begin
        if (regwrite_q && dest_q != '0) regs_d[dest_q] = is_load ? mdr_q : aluout_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      dest_q     <= '0;
      regwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      alu_ctrl_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      aluout_q   <= '0;
      mdr_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      dest_q     <= dest_d;
      regwrite_q <= regwrite_d;
      alusrc_q   <= alusrc_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      alu_ctrl_q <= alu_ctrl_d;
      a_q        <= a_d;
      b_q        <= b_d;
      imm_q      <= imm_d;
      aluout_q   <= aluout_d;
      mdr_q      <= mdr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign instr_ready    = (state_q == IDLE);
  assign done           = (state_q == WB);
  assign data_read      = (state_q == MEM) && is_load;
  assign data_write     = (state_q == MEM) && memwrite_q;
  assign data_address   = addr_q;
  assign data_writedata = wdata_q;
  assign dbg_data       = regs_q[dbg_addr];

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: default 32x32 build plus a 16-bit, 8-register build.
module tb_datapath_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, instr_ready;
  logic [4:0]  rs, rt, rd, dbg_addr;
  logic        RegDst, RegWrite, ALUSrc, ZeroExt, MemRead, MemWrite;
  logic [2:0]  alu_ctrl;
  logic [15:0] alu_immediate;
  logic        done, data_read, data_write, data_waitrequest;
  logic [31:0] data_address, data_writedata, data_readdata, dbg_data;

  logic        s_valid, s_ready, s_done, s_rd_req, s_wr_req;
  logic [2:0]  s_rs, s_rt, s_rd, s_dbg_addr, s_ctrl;
  logic        s_regdst, s_alusrc;
  logic [15:0] s_imm, s_addr, s_wdata, s_dbg_data;

  int checks = 0;
  int errors = 0;
  int mem_waits = 0;
  int wcnt = 0;
  logic [31:0] mem_rdata = 32'h0;

  int lat, memcyc, rdy_low, unstable;
  logic saw_read, done_after, ready_after;
  logic [31:0] req_addr, req_wdata;

  always #5 clk = ~clk;

  // Memory model: stalls for mem_waits cycles at the start of every request.
  assign data_waitrequest = (data_read | data_write) && (wcnt < mem_waits);
  assign data_readdata    = mem_rdata;
  always @(posedge clk) wcnt <= (data_read | data_write) ? wcnt + 1 : 0;

  datapath_mc u_dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rs(rs), .rt(rt), .rd(rd), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .ZeroExt(ZeroExt), .MemRead(MemRead), .MemWrite(MemWrite), .alu_ctrl(alu_ctrl),
    .alu_immediate(alu_immediate), .done(done), .data_address(data_address),
    .data_writedata(data_writedata), .data_read(data_read), .data_write(data_write),
    .data_waitrequest(data_waitrequest), .data_readdata(data_readdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  datapath_mc #(.XLEN(16), .NREGS(8)) u_small (
    .clk(clk), .reset(reset), .instr_valid(s_valid), .instr_ready(s_ready),
    .rs(s_rs), .rt(s_rt), .rd(s_rd), .RegDst(s_regdst), .RegWrite(1'b1), .ALUSrc(s_alusrc),
    .ZeroExt(1'b0), .MemRead(1'b0), .MemWrite(1'b0), .alu_ctrl(s_ctrl),
    .alu_immediate(s_imm), .done(s_done), .data_address(s_addr),
    .data_writedata(s_wdata), .data_read(s_rd_req), .data_write(s_wr_req),
    .data_waitrequest(1'b0), .data_readdata(16'h0),
    .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic s_chk_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
    s_dbg_addr = idx;
    #1;
    check(tag, s_dbg_data, exp);
  endtask

  // Issue one instruction, scramble the fields after accept, and trace until done.
  task automatic exec_instr(input logic [4:0] rs_i, input logic [4:0] rt_i, input logic [4:0] rd_i,
                            input logic regdst_i, input logic regwrite_i, input logic alusrc_i,
                            input logic zeroext_i, input logic memread_i, input logic memwrite_i,
                            input logic [2:0] op_i, input logic [15:0] imm_i);
    rs = rs_i; rt = rt_i; rd = rd_i; RegDst = regdst_i; RegWrite = regwrite_i;
    ALUSrc = alusrc_i; ZeroExt = zeroext_i; MemRead = memread_i; MemWrite = memwrite_i;
    alu_ctrl = op_i; alu_immediate = imm_i; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rs = ~rs_i; rt = ~rt_i; rd = ~rd_i; RegDst = ~regdst_i; RegWrite = 1'b0;
    ALUSrc = ~alusrc_i; ZeroExt = ~zeroext_i; MemRead = 1'b0; MemWrite = 1'b0;
    alu_ctrl = ~op_i; alu_immediate = ~imm_i;
    lat = 1; memcyc = 0; rdy_low = 0; unstable = 0; saw_read = 1'b0;
    req_addr = '0; req_wdata = '0;
    while (!done && lat < 40) begin
      if (!instr_ready) rdy_low++;
      if (data_read || data_write) begin
        if (memcyc == 0) begin
          req_addr = data_address;
          req_wdata = data_writedata;
        end else if (data_address !== req_addr || data_writedata !== req_wdata) begin
          unstable++;
        end
        memcyc++;
        if (data_read) saw_read = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!instr_ready) rdy_low++;
    check("done_seen", done, 1);
    @(posedge clk); #1;
    done_after = done;
    ready_after = instr_ready;
  endtask

  task automatic s_exec(input logic [2:0] rs_i, input logic [2:0] rt_i, input logic [2:0] rd_i,
                        input logic regdst_i, input logic alusrc_i, input logic [2:0] op_i,
                        input logic [15:0] imm_i);
    int n;
    s_rs = rs_i; s_rt = rt_i; s_rd = rd_i; s_regdst = regdst_i; s_alusrc = alusrc_i;
    s_ctrl = op_i; s_imm = imm_i; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    n = 0;
    while (!s_done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("s_done_seen", s_done, 1);
    @(posedge clk); #1;
  endtask

  logic [31:0] alu_exp [8] = '{32'hDEADBEF4, 32'hDEADBEEA, 32'h00000005, 32'hDEADBEEF,
                               32'hDEADBEEA, 32'h00000001, 32'h00000000, 32'h21524110};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0; instr_valid = 1'b0; rs = '0; rt = '0; rd = '0; dbg_addr = '0;
    RegDst = 1'b0; RegWrite = 1'b0; ALUSrc = 1'b0; ZeroExt = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; alu_ctrl = '0; alu_immediate = '0;
    s_valid = 1'b0; s_rs = '0; s_rt = '0; s_rd = '0; s_dbg_addr = '0; s_ctrl = '0;
    s_regdst = 1'b0; s_alusrc = 1'b0; s_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_rw", {data_read, data_write}, 0);
    check("rst_addr", data_address, 0);
    check("rst_wdata", data_writedata, 0);
    reset = 1'b1;
    chk_reg("rst_r1", 1, 0);

    // ADDI r1 = 5
    exec_instr(0, 1, 0, 1, 1, 1, 0, 0, 0, 3'd0, 16'h0005);
    check("addi_lat", lat, 2);
    check("addi_rdy_low", rdy_low, 2);
    check("addi_done_once", done_after, 0);
    check("addi_ready_after", ready_after, 1);
    chk_reg("addi_r1", 1, 32'h5);

    exec_instr(0, 2, 0, 1, 1, 1, 1, 0, 0, 3'd0, 16'hFFFF);
    chk_reg("zext_r2", 2, 32'h0000FFFF);
    exec_instr(0, 2, 0, 1, 1, 1, 0, 0, 0, 3'd0, 16'hFFFF);
    chk_reg("sext_r2", 2, 32'hFFFFFFFF);
    exec_instr(2, 1, 3, 0, 1, 0, 0, 0, 0, 3'd5, 16'h0);
    chk_reg("slt_r3", 3, 32'h1);
    exec_instr(2, 1, 4, 0, 1, 0, 0, 0, 0, 3'd6, 16'h0);
    chk_reg("sltu_r4", 4, 32'h0);

    // Loads: zero waits into r6, then two waits into r2
    mem_waits = 0; mem_rdata = 32'h12345678;
    exec_instr(1, 6, 0, 1, 1, 1, 0, 1, 0, 3'd0, 16'h0);
    check("ld0_lat", lat, 3);
    check("ld0_memcyc", memcyc, 1);
    check("ld0_addr", req_addr, 32'h5);
    chk_reg("ld0_r6", 6, 32'h12345678);
    mem_waits = 2; mem_rdata = 32'hDEADBEEF;
    exec_instr(1, 2, 0, 1, 1, 1, 0, 1, 0, 3'd0, 16'h0);
    check("ld2_lat", lat, 5);
    check("ld2_memcyc", memcyc, 3);
    chk_reg("ld2_r2", 2, 32'hDEADBEEF);

    // Store with three waits; RegDst points at r2 but RegWrite is off
    mem_waits = 3; mem_rdata = 32'h0;
    exec_instr(1, 2, 0, 1, 0, 1, 0, 0, 1, 3'd0, 16'h0010);
    check("st_lat", lat, 6);
    check("st_memcyc", memcyc, 4);
    check("st_addr", req_addr, 32'h15);
    check("st_wdata", req_wdata, 32'hDEADBEEF);
    check("st_unstable", unstable, 0);
    check("st_no_read", saw_read, 0);
    check("st_done_once", done_after, 0);
    check("st_addr_hold", data_address, 32'h15);
    check("st_write_low", data_write, 0);
    chk_reg("st_r1", 1, 32'h5);
    chk_reg("st_r2", 2, 32'hDEADBEEF);
    chk_reg("st_r6", 6, 32'h12345678);

    // MemRead and MemWrite together behave as a store
    mem_waits = 0;
    exec_instr(1, 6, 0, 1, 0, 1, 0, 1, 1, 3'd0, 16'h0020);
    check("rw_memcyc", memcyc, 1);
    check("rw_no_read", saw_read, 0);
    check("rw_addr", req_addr, 32'h25);
    check("rw_wdata", req_wdata, 32'h12345678);

    for (int i = 0; i < 8; i++) begin
      exec_instr(2, 1, 8, 0, 1, 0, 0, 0, 0, 3'(i), 16'h0);
      check($sformatf("alu_lat_op%0d", i), lat, 2);
      chk_reg($sformatf("alu_res_op%0d", i), 8, alu_exp[i]);
    end

    exec_instr(0, 0, 0, 1, 1, 1, 0, 0, 0, 3'd0, 16'h0007);
    check("r0_lat", lat, 2);
    chk_reg("r0_zero", 0, 32'h0);

    // Reset while a load is stalled in MEM
    mem_waits = 100; mem_rdata = 32'hCAFEF00D;
    rs = 1; rt = 9; rd = 0; RegDst = 1'b1; RegWrite = 1'b1; ALUSrc = 1'b1; ZeroExt = 1'b0;
    MemRead = 1'b1; MemWrite = 1'b0; alu_ctrl = 3'd0; alu_immediate = 16'h0; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; MemRead = 1'b0; RegWrite = 1'b0;
    n = 0;
    while (!data_read && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("mrst_req_before", data_read, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mrst_read_drop", data_read, 0);
    check("mrst_ready", instr_ready, 1);
    check("mrst_done", done, 0);
    chk_reg("mrst_r1", 1, 0);
    chk_reg("mrst_r2", 2, 0);
    chk_reg("mrst_r6", 6, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    mem_waits = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("mrst_no_done", n, 0);
    chk_reg("mrst_r9", 9, 0);

    // 16-bit, 8-register build
    s_exec(0, 1, 0, 1, 1, 3'd0, 16'h0001);
    s_exec(0, 1, 7, 0, 0, 3'd1, 16'h0);
    s_chk_reg("s_r7_sub", 7, 16'hFFFF);
    s_chk_reg("s_r1", 1, 16'h0001);
    s_exec(0, 2, 0, 1, 1, 3'd0, 16'h8000);
    s_chk_reg("s_r2_sext", 2, 16'h8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
